gamepad_pmod_multi: RTL and testbench



---
 rtl/gamepad_pkg.sv | 35 +++
 rtl/gamepad_sync_edge.sv | 30 +++
 rtl/gamepad_pmod_multi.sv | 178 +++++++++++++++++
 tb/tb_gamepad_pmod_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// Shared constants for the chained SNES-compatible gamepad Pmod decoder.
// Pad layout, button indices, absent-pad marker and frame-length helper.
package gamepad_pkg;

  localparam int BITS_PER_PAD = 12;

  // Bit positions within one pad's 12-bit slice, MSB first on the wire.
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  // An unplugged pad's data line floats high for its whole slice.
  localparam logic [BITS_PER_PAD-1:0] PAD_ABSENT = 12'hFFF;

  // Outcome of the most recent latch, consumed by the output stage next cycle.
  typedef enum logic [1:0] {
    LATCH_IDLE = 2'd0,
    LATCH_GOOD = 2'd1,
    LATCH_BAD  = 2'd2
  } latch_status_t;

  function automatic int frame_bits(input int n);
    return BITS_PER_PAD * n;
  endfunction

endpackage

// File: rtl/gamepad_sync_edge.sv
// Two-flop synchroniser for one asynchronous Pmod line, plus a history flop
// so a rising edge shows up as a single-cycle pulse in the clk domain.
module gamepad_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~hist;

endmodule

// File: rtl/gamepad_pmod_multi.sv
// Multi-pad gamepad Pmod decoder: deserialises NUM_PADS chained pads, checks
// frame length, and produces held levels, press pulses and presence flags.
// Define GAMEPAD_REPEAT_EN to add auto-repeat press pulses on the d-pad.
module gamepad_pmod_multi
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pmod_data,
  input  logic                         pmod_clk,
  input  logic                         pmod_latch,
  output logic [12*NUM_PADS-1:0]       buttons,
  output logic [12*NUM_PADS-1:0]       pressed,
  output logic [NUM_PADS-1:0]          present,
  output logic                         frame_valid,
  output logic                         frame_error
);

  localparam int FRAME_BITS = frame_bits(NUM_PADS);
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  logic data_sync;
  logic data_rise;
  logic clk_level;
  logic clk_rise;
  logic latch_level;
  logic latch_rise;

  gamepad_sync_edge u_sync_data (
    .clk      (clk),
    .rst      (rst),
    .async_in (pmod_data),
    .level    (data_sync),
    .rise     (data_rise)
  );

  gamepad_sync_edge u_sync_clk (
    .clk      (clk),
    .rst      (rst),
    .async_in (pmod_clk),
    .level    (clk_level),
    .rise     (clk_rise)
  );

  gamepad_sync_edge u_sync_latch (
    .clk      (clk),
    .rst      (rst),
    .async_in (pmod_latch),
    .level    (latch_level),
    .rise     (latch_rise)
  );

  logic unused_sync;
  assign unused_sync = data_rise ^ clk_level ^ latch_level;

  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] data_reg;
  logic [CNT_W-1:0]      bit_cnt;
  latch_status_t         latch_status;

  // A latch edge takes priority over a coincident shift edge; the dropped
  // shift leaves the frame short so it is rejected rather than misaligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      data_reg     <= '1;
      bit_cnt      <= '0;
      latch_status <= LATCH_IDLE;
    end else begin
      latch_status <= LATCH_IDLE;
      if (latch_rise) begin
        bit_cnt <= '0;
        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
          data_reg     <= shift_reg;
          latch_status <= LATCH_GOOD;
        end else begin
          latch_status <= LATCH_BAD;
        end
      end else if (clk_rise) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], data_sync};
        if (bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  logic [FRAME_BITS-1:0] next_buttons;
  logic [NUM_PADS-1:0]   next_present;

  always_comb begin
    next_buttons = '0;
    next_present = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      if (data_reg[k*BITS_PER_PAD +: BITS_PER_PAD] != PAD_ABSENT) begin
        next_present[k] = 1'b1;
        next_buttons[k*BITS_PER_PAD +: BITS_PER_PAD] = data_reg[k*BITS_PER_PAD +: BITS_PER_PAD];
      end
    end
  end

  logic [FRAME_BITS-1:0] repeat_hits;

`ifdef GAMEPAD_REPEAT_EN
  localparam int RPT_W   = $clog2(REPEAT_DELAY + 1);
  localparam int RELOAD  = (REPEAT_RATE > REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_RATE + 1;
  localparam int NUM_DIR = 4;

  // One counter per pad per direction (right, left, down, up = bits 4..7).
  // The value is the number of earlier consecutive held frames; reaching
  // REPEAT_DELAY fires a repeat and reloads so the next fires REPEAT_RATE later.
  logic [RPT_W-1:0] rpt_cnt [NUM_PADS*NUM_DIR];

  always_comb begin
    repeat_hits = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      for (int d = 0; d < NUM_DIR; d++) begin
        if (next_buttons[k*BITS_PER_PAD + BTN_RIGHT + d] &&
            rpt_cnt[k*NUM_DIR + d] == RPT_W'(REPEAT_DELAY)) begin
          repeat_hits[k*BITS_PER_PAD + BTN_RIGHT + d] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PADS*NUM_DIR; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else if (latch_status == LATCH_GOOD) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        for (int d = 0; d < NUM_DIR; d++) begin
          if (!next_buttons[k*BITS_PER_PAD + BTN_RIGHT + d]) begin
            rpt_cnt[k*NUM_DIR + d] <= '0;
          end else if (rpt_cnt[k*NUM_DIR + d] == RPT_W'(REPEAT_DELAY)) begin
            rpt_cnt[k*NUM_DIR + d] <= RPT_W'(RELOAD);
          end else begin
            rpt_cnt[k*NUM_DIR + d] <= rpt_cnt[k*NUM_DIR + d] + RPT_W'(1);
          end
        end
      end
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY == 0) ^ (REPEAT_RATE == 0);
  assign repeat_hits   = '0;
`endif

  // Output stage runs one cycle after the latch so data_reg is already settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons     <= '0;
      pressed     <= '0;
      present     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      pressed     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (latch_status == LATCH_GOOD) begin
        buttons     <= next_buttons;
        present     <= next_present;
        pressed     <= (next_buttons & ~buttons) | repeat_hits;
        frame_valid <= 1'b1;
      end else if (latch_status == LATCH_BAD) begin
        frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Randomised bench for gamepad_pmod_multi against a frame-level reference
// model; honours GAMEPAD_REPEAT_EN when the design is built with it.
module tb_gamepad_pmod_multi;

  localparam int NUM_PADS = 2;
  localparam int FB       = 12 * NUM_PADS;
  localparam int DELAY    = 3;
  localparam int RATE     = 2;
`ifdef GAMEPAD_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                pmod_data;
  logic                pmod_clk;
  logic                pmod_latch;
  logic [FB-1:0]       buttons;
  logic [FB-1:0]       pressed;
  logic [NUM_PADS-1:0] present;
  logic                frame_valid;
  logic                frame_error;

  gamepad_pmod_multi #(
    .NUM_PADS     (NUM_PADS),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pmod_data   (pmod_data),
    .pmod_clk    (pmod_clk),
    .pmod_latch  (pmod_latch),
    .buttons     (buttons),
    .pressed     (pressed),
    .present     (present),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: pads as 12-bit words, d-pad hold lengths in frames
  logic [FB-1:0]       m_buttons;
  logic [NUM_PADS-1:0] m_present;
  int                  m_held [NUM_PADS][4];
  logic [FB-1:0]       exp_q[$];

  task automatic model_reset();
    m_buttons = '0;
    m_present = '0;
    for (int k = 0; k < NUM_PADS; k++)
      for (int d = 0; d < 4; d++) m_held[k][d] = 0;
  endtask

  task automatic model_frame(input logic [FB-1:0] f, output logic [FB-1:0] exp_pressed);
    logic [FB-1:0] nb;
    logic [11:0]   slice;
    nb = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      slice = f[k*12 +: 12];
      m_present[k] = (slice != 12'hFFF);
      if (m_present[k]) nb[k*12 +: 12] = slice;
    end
    exp_pressed = nb & ~m_buttons;
    for (int k = 0; k < NUM_PADS; k++) begin
      for (int d = 0; d < 4; d++) begin
        // d = 0..3 covers right, left, down, up (bits 4..7 of the pad)
        if (nb[k*12 + 4 + d]) m_held[k][d]++;
        else                  m_held[k][d] = 0;
        if (RPT_ON && m_held[k][d] > DELAY && ((m_held[k][d] - 1 - DELAY) % RATE) == 0)
          exp_pressed[k*12 + 4 + d] = 1'b1;
      end
    end
    m_buttons = nb;
  endtask

  // drivers
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      pmod_data = bits[i];
      repeat (3) @(negedge clk);
      pmod_clk = 1'b1;
      repeat (4) @(negedge clk);
      pmod_clk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic latch_frame(input bit good, input logic [FB-1:0] f, input string tag);
    logic [FB-1:0] exp_pressed;
    logic [FB-1:0] exp_buttons;
    logic [FB-1:0] got_pressed;
    int fv_cnt, fe_cnt, pr_cnt, pulse_at;
    exp_pressed = '0;
    if (good) begin
      model_frame(f, exp_pressed);
      exp_q.push_back(m_buttons);
    end
    fv_cnt = 0; fe_cnt = 0; pr_cnt = 0; pulse_at = -1; got_pressed = '0;
    @(negedge clk);
    pmod_latch = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_valid) fv_cnt++;
      if (frame_error) fe_cnt++;
      if ((frame_valid || frame_error) && pulse_at < 0) pulse_at = i;
      if (pressed != '0) begin
        pr_cnt++;
        got_pressed = pressed;
      end
      if (i == 4) pmod_latch = 1'b0;
    end
    check_eq({tag, ".frame_valid_cnt"}, 64'(fv_cnt), good ? 64'd1 : 64'd0);
    check_eq({tag, ".frame_error_cnt"}, 64'(fe_cnt), good ? 64'd0 : 64'd1);
    check_eq({tag, ".latency"}, 64'(pulse_at), 64'd3);
    exp_buttons = m_buttons;
    if (good && exp_q.size() > 0) exp_buttons = exp_q.pop_front();
    check_eq({tag, ".buttons"}, 64'(buttons), 64'(exp_buttons));
    check_eq({tag, ".present"}, 64'(present), 64'(m_present));
    check_eq({tag, ".pressed"}, 64'(got_pressed), 64'(exp_pressed));
    check_eq({tag, ".pressed_cycles"}, 64'(pr_cnt), (exp_pressed != '0) ? 64'd1 : 64'd0);
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input string tag);
    send_bits(32'(f), FB);
    latch_frame(1'b1, f, tag);
  endtask

  task automatic send_short(input int n, input string tag);
    send_bits($urandom(), n);
    latch_frame(1'b0, '0, tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("reset.buttons", 64'(buttons), 64'd0);
    check_eq("reset.present", 64'(present), 64'd0);
    check_eq("reset.pressed", 64'(pressed), 64'd0);
  endtask

  function automatic logic [11:0] rand_pad(input logic [11:0] prev);
    case ($urandom_range(0, 3))
      0:       return 12'hFFF;
      1:       return prev;
      2:       return prev ^ (12'h1 << $urandom_range(0, 11));
      default: return 12'($urandom());
    endcase
  endfunction

  initial begin
    logic [FB-1:0] f;
    int n;
    rst = 1'b1; pmod_data = 1'b0; pmod_clk = 1'b0; pmod_latch = 1'b0;
    model_reset();
    apply_reset();

    latch_frame(1'b0, '0, "empty_latch");

    send_frame({12'hFFF, 12'h800}, "pad0_b");
    send_frame({12'hFFF, 12'h800}, "pad0_b_again");
    send_short(FB - 1, "short23");
    send_short(FB + 1, "long25");

    send_bits(32'h3FF, 10);
    apply_reset();
    send_frame({12'hFFF, 12'h0A5}, "after_mid_reset");

    // hold up on pad0 for 8 frames, release, press again
    for (int i = 1; i <= 8; i++) send_frame({12'hFFF, 12'h080}, $sformatf("hold_up%0d", i));
    send_frame({12'hFFF, 12'h000}, "release_up");
    send_frame({12'hFFF, 12'h080}, "repress_up");

    send_frame({12'h010, 12'hFFF}, "hotplug_pad1");

    f = {12'h010, 12'hFFF};
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 30);
        if (n == FB) n = FB + 1;
        send_short(n, $sformatf("rand_err%0d", t));
      end else begin
        for (int k = 0; k < NUM_PADS; k++) f[k*12 +: 12] = rand_pad(f[k*12 +: 12]);
        send_frame(f, $sformatf("rand%0d", t));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
